// File: rtl/signed_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : signed_mult_pipe
// Purpose  : Fully pipelined signed fixed-point multiplier with valid/ready
//            handshake, round-half-away-from-zero scaling and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module signed_mult_pipe #(
    parameter int WIDTH       = 16,
    parameter int FRAC        = 0,
    parameter int OUT_WIDTH   = 32,
    parameter int ROUND       = 1,
    parameter int MULT_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] P,
    output logic                 ovf
);

    localparam int c_prod_w  = 2 * WIDTH;
    localparam int c_q_w     = 2 * WIDTH + 1;
    localparam int c_half    = WIDTH / 2;
    localparam int c_lo_w    = WIDTH + c_half;
    localparam int c_rnd_sh  = (FRAC > 0) ? FRAC - 1 : 0;

    localparam logic [c_q_w-1:0] c_round   = (ROUND != 0 && FRAC > 0) ?
                                             (c_q_w'(1) << c_rnd_sh) : '0;
    localparam logic [c_q_w-1:0] c_neg_mag = c_q_w'(1) << (OUT_WIDTH - 1);
    localparam logic [c_q_w-1:0] c_pos_max = c_neg_mag - c_q_w'(1);

    // ------------------------------------------------------------------
    // Handshake: one global advance enable, stall only when output is held
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_adv;
    logic r_out_valid;

    assign w_stall   = r_out_valid & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;

    // ------------------------------------------------------------------
    // Valid chain (the only reset state besides the output register)
    // ------------------------------------------------------------------
    logic                   r_s0_valid;
    logic [MULT_STAGES-1:0] r_m_valid;
    logic                   r_sf_valid;
    logic [OUT_WIDTH-1:0]   r_p;
    logic                   r_ovf;
    logic [OUT_WIDTH-1:0]   w_p;
    logic                   w_ovf;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_s0_valid  <= 1'b0;
            r_m_valid   <= '0;
            r_sf_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_s0_valid   <= in_valid;
            r_m_valid[0] <= r_s0_valid;
            for (int i = 1; i < MULT_STAGES; i++) begin
                r_m_valid[i] <= r_m_valid[i-1];
            end
            r_sf_valid  <= r_m_valid[MULT_STAGES-1];
            r_out_valid <= r_sf_valid;
            // Holding P through bubbles keeps it free of stale data
            if (r_sf_valid) begin
                r_p   <= w_p;
                r_ovf <= w_ovf;
            end
        end
    end

    assign P   = r_p;
    assign ovf = r_ovf;

    // ------------------------------------------------------------------
    // S0: sign and magnitude capture
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] r_s0_mag_a;
    logic [WIDTH-1:0] r_s0_mag_b;
    logic             r_s0_sign;

    // The most negative operand maps to 100..0, exact as an unsigned value
    assign w_mag_a = A[WIDTH-1] ? -A : A;
    assign w_mag_b = B[WIDTH-1] ? -B : B;

    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_s0_mag_a <= w_mag_a;
            r_s0_mag_b <= w_mag_b;
            r_s0_sign  <= A[WIDTH-1] ^ B[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Unsigned magnitude multiplier, MULT_STAGES registers deep
    // ------------------------------------------------------------------
    logic [MULT_STAGES-1:0] r_m_sign;
    logic [c_prod_w-1:0]    w_mult_out;

    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_m_sign[0] <= r_s0_sign;
            for (int i = 1; i < MULT_STAGES; i++) begin
                r_m_sign[i] <= r_m_sign[i-1];
            end
        end
    end

    generate
        if (MULT_STAGES >= 2) begin : g_split
            // Two half-width partial products, then an aligned sum
            logic [c_lo_w-1:0]   r_pp_lo;
            logic [c_prod_w-1:0] r_pp_hi;
            logic [c_prod_w-1:0] r_prod_pipe [MULT_STAGES-1];

            always_ff @(posedge CLK) begin
                if (w_adv) begin
                    r_pp_lo <= c_lo_w'(r_s0_mag_a) * c_lo_w'(r_s0_mag_b[c_half-1:0]);
                    r_pp_hi <= c_prod_w'(r_s0_mag_a) * c_prod_w'(r_s0_mag_b[WIDTH-1:c_half]);
                    r_prod_pipe[0] <= c_prod_w'(r_pp_lo) + (r_pp_hi << c_half);
                    for (int i = 1; i < MULT_STAGES - 1; i++) begin
                        r_prod_pipe[i] <= r_prod_pipe[i-1];
                    end
                end
            end

            assign w_mult_out = r_prod_pipe[MULT_STAGES-2];
        end else begin : g_single
            logic [c_prod_w-1:0] r_prod;

            always_ff @(posedge CLK) begin
                if (w_adv) begin
                    r_prod <= c_prod_w'(r_s0_mag_a) * c_prod_w'(r_s0_mag_b);
                end
            end

            assign w_mult_out = r_prod;
        end
    endgenerate

    // ------------------------------------------------------------------
    // S_F: rounding and scaling with one spare carry bit
    // ------------------------------------------------------------------
    logic [c_q_w-1:0] w_sum;
    logic [c_q_w-1:0] w_q;
    logic [c_q_w-1:0] r_sf_q;
    logic             r_sf_sign;

    assign w_sum = {1'b0, w_mult_out} + c_round;
    assign w_q   = w_sum >> FRAC;

    always_ff @(posedge CLK) begin
        if (w_adv) begin
            r_sf_q    <= w_q;
            r_sf_sign <= r_m_sign[MULT_STAGES-1];
        end
    end

    // Saturation is decided on the magnitude, before the sign is applied
    always_comb begin
        w_ovf = 1'b0;
        w_p   = r_sf_q[OUT_WIDTH-1:0];
        if (!r_sf_sign && (r_sf_q > c_pos_max)) begin
            w_p   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            w_ovf = 1'b1;
        end else if (r_sf_sign && (r_sf_q > c_neg_mag)) begin
            w_p   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            w_ovf = 1'b1;
        end else if (r_sf_sign) begin
            w_p   = -r_sf_q[OUT_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: doc/signed_mult_pipe.md
# signed_mult_pipe

Parametrised, fully pipelined signed fixed-point multiplier with valid/ready handshake, round-to-nearest scaling and output saturation. It replaces the fixed 16-bit enable-sequenced multiplier in the eigenvalue datapath. It accepts one operand pair per cycle, tolerates downstream backpressure and returns a signed product of configurable width and fractional alignment.

## Interface
- WIDTH, 16: operand width, signed two's complement, ≥ 2
- FRAC, 0: product right-shift (fractional bits removed), 0 ≤ FRAC < 2*WIDTH
- OUT_WIDTH, 32: result width, signed, 2 ≤ OUT_WIDTH ≤ 2*WIDTH
- ROUND, 1: 1 = round half away from zero, 0 = truncate toward zero
- MULT_STAGES, 2: register stages inside the unsigned magnitude multiplier, ≥ 1
- CLK  in  1  clock, all logic on rising edge
- RSTN  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept this cycle
- A  in  WIDTH  multiplicand, signed
- B  in  WIDTH  multiplier, signed
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- P  out  OUT_WIDTH  signed result
- ovf  out  1  P was saturated, qualified by out_valid

## Operation
- Pipeline: S0 sign/magnitude capture → MULT_STAGES unsigned product stages → S_F scale/round/saturate/negate → output register. Each stage carries a valid bit.
- S0: sign = A[W-1] ^ B[W-1]; |A|, |B| as WIDTH-bit unsigned. −2^(WIDTH−1) has magnitude 2^(WIDTH−1); no truncation.
- Product: M = |A|·|B|, 2*WIDTH bits unsigned, exact.
- Scale: ROUND=1 and FRAC>0: Q = (M + 2^(FRAC−1)) >> FRAC. Otherwise Q = M >> FRAC. Computed in 2*WIDTH+1 bits, so the carry is never lost.
- Saturate on magnitude, before negation:
  - sign=0 and Q > 2^(OUT_WIDTH−1)−1 → P = 0x7F..F, ovf=1
  - sign=1 and Q > 2^(OUT_WIDTH−1) → P = 0x80..0, ovf=1
  - otherwise P = sign ? −Q : Q, ovf=0
- Q = 0 gives P = 0 whatever the sign.
- Handshake:
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall, a combinational path from out_ready.
  - No stall: every stage advances and bubbles propagate as valid=0. Stall: all stages and the output hold.
  - P and ovf stay stable while out_valid & ~out_ready.
- Results leave in acceptance order. None are lost or duplicated.
- in_valid is allowed while in_ready=0; the inputs are ignored that cycle and the source must hold them.

## Timing
- Latency: an operand pair accepted at edge k produces out_valid=1 with its P after edge k+MULT_STAGES+2, provided no stall occurs. Every stall cycle adds one cycle.
- Throughput: 1 result per cycle while out_ready=1.
- Reset (RSTN=0 at a rising edge): all stage valids, out_valid, P and ovf are 0 after that edge. in_ready reads 1 from the first cycle after reset, since stall=0.
- Reset mid-operation: in-flight data is discarded and no result for it is ever presented. in_valid during reset is ignored.
- Data registers other than P and ovf need no reset. The valid bits must be reset.
- Simultaneous output transfer and new input in the same cycle: both complete, with no bubble inserted.

## Test plan
- Default parameters, boundary operands:
  - A=0x8000, B=0x8000 → P=0x40000000, ovf=0
  - A=0x8000, B=0x7FFF → P=0xC0008000
  - A=0x0000, B=0x8000 → P=0x00000000
  - Each result appears exactly 4 cycles after acceptance.
- FRAC=8, OUT_WIDTH=16, ROUND=1, Q8.8 scaling:
  - A=0x0180 (1.5), B=0xFF00 (−1.0) → P=0xFE80
  - A=0x0001, B=0x0080 → P=0x0001 (0.5 rounds up)
  - A=0xFFFF, B=0x0080 → P=0xFFFF
- Same configuration with ROUND=0: A=0x0001, B=0x0080 → P=0x0000. A=0xFFFF, B=0x0080 → P=0x0000 (truncation toward zero).
- Saturation at FRAC=8, OUT_WIDTH=16:
  - A=0x7FFF, B=0x7FFF → P=0x7FFF, ovf=1
  - A=0x8000, B=0x7FFF → P=0x8000, ovf=1
  - A=0x0100, B=0x8000 → P=0x8000, ovf=0 (exact minimum, not saturated)
- Backpressure:
  - Stream 8 random pairs back-to-back while out_ready toggles on a 1-high, 2-low pattern.
  - Scoreboard against a reference model: same order, no loss or duplication.
  - P and ovf stay stable while stalled. in_ready == ~(out_valid & ~out_ready) on every cycle.
- Reset mid-stream: drop RSTN for 1 cycle with 3 results in flight.
  - Next cycle: out_valid=0, P=0, ovf=0, in_ready=1.
  - None of the 3 in-flight results ever appears.
  - A pair accepted afterwards returns correctly after MULT_STAGES+2 cycles.
